mux_rr_arbiter_8: RTL and testbench
===================================

Name: mux_rr_arbiter_8

Overview:
- Round-robin arbiter that shares one 8:1 single-bit mux among 8 requesters.
- Sequences the mux select lines so each requester gets exclusive, fair access to the mux output.
- Sits between the requesters and the mux.
  - Drives the select lines and a one-hot grant.
  - Gates the muxed bit with a busy qualifier.

Parameters:
- MAX_HOLD, 8, max consecutive grant cycles per requester when the timeout feature is compiled in; legal range 1..15.
- CNT_W, 4, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock; only clock in the block
- rst  input  1  synchronous, active-high reset
- req  input  8  request vector; req[i] high = requester i wants the mux
- I  input  8  data inputs; I[i] belongs to requester i
- gnt  output  8  registered one-hot grant; all zero when idle
- S2  output  1  mux select MSB (registered)
- S1  output  1  mux select bit 1 (registered)
- S0  output  1  mux select LSB (registered)
- busy  output  1  registered; high while a grant is active
- Y  output  1  muxed data, I[{S2,S1,S0}] when busy, else 0 (combinational from registered selects)

Behaviour:
- Reset (rst=1 at a clk edge):
  - gnt=0, {S2,S1,S0}=0, busy=0, hold count=0, state=IDLE.
  - Round-robin pointer ptr=0, so requester 0 has top priority after reset.
  - Reset mid-grant drops the grant on that same edge. No output glitch beyond Y=0 once busy falls.
- States: IDLE and GRANT, 1-bit state register.
- Pick function:
  - Takes the first i with req[i]=1, scanning ptr, ptr+1, ... ptr+7 modulo 8. Wrap from 7 to 0 is required.
- IDLE:
  - If req != 0: next edge loads gnt=onehot(pick), sel=pick, busy=1, hold=0, goes to GRANT.
  - Latency from req rising to gnt/busy high is 1 cycle.
- GRANT, owner k = {S2,S1,S0}:
  - Hold: req[k]=1 and no timeout. Grant unchanged, hold increments, saturating at MAX_HOLD.
  - Release: req[k]=0, or timeout fires. Set ptr=k+1 mod 8.
    - If other requests are pending, re-arbitrate on that same edge using the new ptr: new owner granted, hold=0, stays in GRANT. There is no idle bubble.
    - If nothing is pending, go to IDLE with gnt=0 and busy=0.
    - The pick excludes k only when k was released by timeout.
  - Simultaneous drop of req[k] and rise of req[j]: j is granted next cycle if it is the first pending from ptr=k+1.
- Only one gnt bit is ever high. gnt bit index always equals {S2,S1,S0} while busy.
- Requests pending in GRANT but not owned are ignored until release. No preemption, except the timeout.
- A requester raising and holding req is granted within 7 grant tenures (starvation-free).

Optional Feature:
- Macro: MUX_ARB_TIMEOUT_EN.
- Defined:
  - Timeout fires when hold reaches MAX_HOLD-1 and at least one other req bit is high. The grant is revoked on that edge, and the owner rotates per the release rule.
  - If no other request is pending, the owner keeps the grant and hold saturates.
- Undefined:
  - The hold counter is not instantiated.
  - The grant persists until req[k] drops.
  - MAX_HOLD and CNT_W are ignored.

Decomposition:
- Package mux_arb_pkg holds:
  - State encoding localparams: ST_IDLE=1'b0, ST_GRANT=1'b1.
  - NUM_REQ=8 and SEL_W=3.
- Sub-module rr_pick8 (combinational):
  - Inputs: req[7:0], ptr[2:0], excl_en, excl_idx[2:0].
  - Outputs: any, idx[2:0].
- The data path instantiates the team's structural mux_8_to_1_str for I to Y_raw, with Y = Y_raw & busy.

Test Plan:
- Reset, then req=8'b0000_0100: gnt=8'h04 and {S2,S1,S0}=3'd2 after 1 cycle. With I=8'h04, Y=1; with I=8'h00, Y=0.
- req=8'hFF held, each owner dropping req for one cycle after 2 cycles of grant: owner sequence 0,1,2,...,7,0 (wrap), with no cycle where busy=0.
- ptr=6 after owner 5 releases, req=8'b0100_0001: requester 6 granted before 0. Then 0 granted after 6 releases.
- Owner 3 drops while req[5] rises in the same cycle: next cycle gnt=8'h20, busy stays 1.
- MUX_ARB_TIMEOUT_EN, MAX_HOLD=4, req[1] and req[2] held high:
  - Owner 1 keeps the grant for exactly 4 cycles, then 2 gets it for 4 cycles, alternating.
  - With only req[1] high, the grant holds indefinitely.
- Assert rst for 1 cycle during GRANT with owner 7: next cycle gnt=0, busy=0, Y=0. With req[7] still high, the grant resumes from ptr=0 scan, so requester 7 is granted if no lower index is pending.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
//   Shared definitions for the round-robin mux arbiter:
//   - state encoding of the arbiter FSM (ST_IDLE / ST_GRANT)
//   - requester count and select width
//   - onehot() helper turning a select index into a grant vector
// ---------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux_8_to_1_str.sv
// ---------------------------------------------------------------------------
// mux_8_to_1_str
//   Structural 8:1 single-bit multiplexer: each input is ANDed with a full
//   decode of its select code and the eight terms are ORed together.
//
// Ports:
//   I[7:0]    in   data inputs
//   S2,S1,S0  in   select, S2 is the MSB
//   Y         out  I[{S2,S1,S0}]
// ---------------------------------------------------------------------------
module mux_8_to_1_str (
    input  logic [7:0] I,
    input  logic       S2,
    input  logic       S1,
    input  logic       S0,
    output logic       Y
);

    logic [7:0] term;

    for (genvar i = 0; i < 8; i++) begin : g_term
        localparam logic [2:0] CODE = 3'(i);
        assign term[i] = I[i] & (S2 ~^ CODE[2]) & (S1 ~^ CODE[1]) & (S0 ~^ CODE[0]);
    end

    assign Y = |term;

endmodule

// File: rtl/rr_pick8.sv
// ---------------------------------------------------------------------------
// rr_pick8
//   Combinational round-robin pick over 8 requesters.
//   Scans ptr, ptr+1, ... ptr+7 (mod 8) and returns the first requester
//   whose request is set, optionally masking out one index.
//
// Ports:
//   req[7:0]      in   request vector
//   ptr[2:0]      in   index scanned first (highest priority)
//   excl_en       in   when high, excl_idx is removed from the scan
//   excl_idx[2:0] in   index to exclude
//   any           out  at least one eligible request
//   idx[2:0]      out  chosen requester (don't-care when any=0)
// ---------------------------------------------------------------------------
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic               excl_en,
    input  logic [SEL_W-1:0]   excl_idx,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] cand;
    logic [SEL_W-1:0]   pos;

    always_comb begin
        cand = req;
        if (excl_en) begin
            cand[excl_idx] = 1'b0;
        end
    end

    // Scan from the farthest offset down to offset 0 so the closest
    // eligible requester to ptr is the last one written. The 3-bit add
    // gives the 7 -> 0 wrap for free.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional write; a path that leaves it unassigned infers a latch.
        any = |cand;
        idx = ptr;
        pos = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            pos = ptr + SEL_W'(off);
            if (cand[pos]) begin
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter_8
//   Round-robin arbiter sharing one 8:1 single-bit mux among 8 requesters.
//   An owner keeps the mux until it drops its request; on release the
//   pointer moves past the owner and the next pending requester is granted
//   on the same edge (no idle bubble).
//
//   Optional feature (macro MUX_ARB_TIMEOUT_EN): an owner that has held the
//   grant for MAX_HOLD cycles while someone else is waiting is forced to
//   release. Without the macro the hold counter does not exist and
//   MAX_HOLD / CNT_W only take part in the configuration sanity check.
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles with the timeout compiled in (1..15)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req[7:0]   in   request vector
//   I[7:0]     in   mux data inputs, I[i] belongs to requester i
//   gnt[7:0]   out  registered one-hot grant, zero when idle
//   S2,S1,S0   out  registered mux select (S2 = MSB)
//   busy       out  registered, high while a grant is active
//   Y          out  I[{S2,S1,S0}] gated by busy
// ---------------------------------------------------------------------------
module mux_rr_arbiter_8
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] I,
    output logic [NUM_REQ-1:0] gnt,
    output logic               S2,
    output logic               S1,
    output logic               S0,
    output logic               busy,
    output logic               Y
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
        $error("mux_rr_arbiter_8: illegal MAX_HOLD/CNT_W combination");
    end

    logic                state;
    logic                state_next;
    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    ptr_next;
    logic [SEL_W-1:0]    sel;
    logic [SEL_W-1:0]    sel_next;
    logic [NUM_REQ-1:0]  gnt_next;
    logic                busy_next;

    logic                owner_req;
    logic                others_pending;
    logic                timeout;
    logic                release_grant;
    logic [SEL_W-1:0]    pick_ptr;
    logic                pick_any;
    logic [SEL_W-1:0]    pick_idx;
    logic                y_raw;

    assign owner_req      = req[sel];
    assign others_pending = |(req & ~onehot(sel));

`ifdef MUX_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold;
    logic [CNT_W-1:0] hold_next;

    // ">=" rather than "==" so a counter that saturated while the owner was
    // alone still times out as soon as a competitor shows up.
    assign timeout = (state == ST_GRANT) && owner_req && others_pending
                     && (hold >= CNT_W'(MAX_HOLD - 1));
`else
    assign timeout = 1'b0;
`endif

    assign release_grant = (state == ST_GRANT) && (!owner_req || timeout);

    // In GRANT the scan always starts just past the owner: that is the
    // pointer value the release stores, so the re-arbitration on the same
    // edge already sees the rotated priority.
    assign pick_ptr = (state == ST_GRANT) ? sel + SEL_W'(1) : ptr;

    rr_pick8 u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .excl_en  (timeout),
        .excl_idx (sel),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of block order.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (pick_any) state_next = ST_GRANT;
            ST_GRANT: if (release_grant && !pick_any) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        ptr_next  = ptr;
        sel_next  = sel;
        gnt_next  = gnt;
        busy_next = busy;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_next  = pick_idx;
                    gnt_next  = onehot(pick_idx);
                    busy_next = 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_grant) begin
                    ptr_next = sel + SEL_W'(1);
                    if (pick_any) begin
                        sel_next  = pick_idx;
                        gnt_next  = onehot(pick_idx);
                        busy_next = 1'b1;
                    end else begin
                        gnt_next  = '0;
                        busy_next = 1'b0;
                    end
                end
            end
            default: begin
                gnt_next  = '0;
                busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            sel  <= '0;
            gnt  <= '0;
            busy <= 1'b0;
        end else begin
            ptr  <= ptr_next;
            sel  <= sel_next;
            gnt  <= gnt_next;
            busy <= busy_next;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    // Restarts on every new grant, counts while the owner holds and
    // saturates at MAX_HOLD.
    always_comb begin
        hold_next = hold;
        if (state == ST_IDLE || release_grant) begin
            hold_next = '0;
        end else if (hold < CNT_W'(MAX_HOLD)) begin
            hold_next = hold + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
        end else begin
            hold <= hold_next;
        end
    end
`endif

    assign {S2, S1, S0} = sel;

    mux_8_to_1_str u_mux (
        .I  (I),
        .S2 (S2),
        .S1 (S1),
        .S0 (S0),
        .Y  (y_raw)
    );

    assign Y = y_raw & busy;

endmodule

// File: tb/tb_mux_rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter_8
//   Directed bench for mux_rr_arbiter_8. Each step drives req/I (and rst),
//   queues the grant expected after the next rising edge, then pops it and
//   compares gnt, busy, select and Y one time unit after that edge.
//   Build with +define+MUX_ARB_TIMEOUT_EN to exercise the timeout (MAX_HOLD=4).
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] I;
    logic [7:0] gnt;
    logic       S2;
    logic       S1;
    logic       S0;
    logic       busy;
    logic       Y;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [7:0] data;
        logic       chk_sel;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    mux_rr_arbiter_8 #(
        .MAX_HOLD (4),
        .CNT_W    (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .I    (I),
        .gnt  (gnt),
        .S2   (S2),
        .S1   (S1),
        .S0   (S0),
        .busy (busy),
        .Y    (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] oh(input int k);
        logic [7:0] v;
        v = 8'h01 << k;
        return v;
    endfunction

    function automatic logic [2:0] idx_of(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus and verify the state after the next edge.
    task automatic step(input logic r_rst, input logic [7:0] r, input logic [7:0] d,
                        input logic [7:0] eg, input string tag);
        exp_t       e;
        logic [2:0] es;
        logic       eb;
        logic       ey;
        rst = r_rst;
        req = r;
        I   = d;
        e.gnt     = eg;
        e.data    = d;
        e.chk_sel = r_rst || (eg != 8'h00);
        e.tag     = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        es = idx_of(e.gnt);
        eb = |e.gnt;
        ey = eb & e.data[es];
        check({e.tag, "/gnt"},  gnt,          e.gnt);
        check({e.tag, "/busy"}, 8'(busy),     8'(eb));
        check({e.tag, "/y"},    8'(Y),        8'(ey));
        if (e.chk_sel) begin
            check({e.tag, "/sel"}, 8'({S2, S1, S0}), 8'(es));
        end
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        req = 8'h00;
        I   = 8'h00;

        // Reset state
        step(1'b1, 8'h00, 8'hFF, 8'h00, "reset0");
        step(1'b1, 8'hFF, 8'hFF, 8'h00, "reset1");

        // Single requester, 1-cycle latency, Y follows I[2]
        step(1'b0, 8'h04, 8'h04, 8'h04, "single_y1");
        step(1'b0, 8'h04, 8'h00, 8'h04, "single_y0");
        step(1'b0, 8'h00, 8'hFF, 8'h00, "single_idle");

        // Full rotation 0..7 and wrap to 0, busy never drops
        step(1'b1, 8'h00, 8'h00, 8'h00, "reset2");
        step(1'b0, 8'hFF, 8'h55, 8'h01, "rr_first");
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            step(1'b0, 8'hFF, d, oh(k), "rr_hold");
            d = 8'($urandom);
            step(1'b0, 8'hFF & ~oh(k), d, oh((k + 1) % 8), "rr_pass");
        end

        // Pointer past 5 gives 6 priority over 0
        step(1'b0, 8'h20, 8'hA5, 8'h20, "own5");
        step(1'b0, 8'h41, 8'h5A, 8'h40, "ptr6_pick6");
        step(1'b0, 8'h41, 8'hFF, 8'h40, "hold6_ignore0");
        step(1'b0, 8'h01, 8'h01, 8'h01, "then0");

        // Owner 3 drops while 5 rises: no bubble
        step(1'b0, 8'h08, 8'h08, 8'h08, "own3");
        step(1'b0, 8'h08, 8'h00, 8'h08, "hold3");
        step(1'b0, 8'h20, 8'h20, 8'h20, "swap3to5");
        step(1'b0, 8'h00, 8'hFF, 8'h00, "idle_after5");

        // Reset during a grant to 7; ptr returns to 0
        step(1'b0, 8'h80, 8'h80, 8'h80, "own7");
        step(1'b1, 8'h80, 8'hFF, 8'h00, "rst_mid7");
        step(1'b0, 8'h80, 8'h80, 8'h80, "regrant7");
        step(1'b1, 8'h81, 8'hFF, 8'h00, "rst_mid7b");
        step(1'b0, 8'h81, 8'h81, 8'h01, "ptr0_after_rst");
        step(1'b0, 8'h00, 8'h00, 8'h00, "idle_end");

`ifdef MUX_ARB_TIMEOUT_EN
        // Owners 1 and 2 alternate every 4 cycles
        step(1'b1, 8'h00, 8'h00, 8'h00, "reset_to");
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                d = 8'($urandom);
                step(1'b0, 8'h06, d, (r % 2 == 0) ? 8'h02 : 8'h04, "timeout_alt");
            end
        end
        // Lone owner keeps the grant
        step(1'b0, 8'h02, 8'h02, 8'h02, "lone1");
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 8'h02, 8'h02, 8'h02, "lone1_hold");
        end
        step(1'b0, 8'h00, 8'h00, 8'h00, "lone1_drop");
`else
        // No preemption: owner 1 keeps the mux while 2 waits
        step(1'b1, 8'h00, 8'h00, 8'h00, "reset_np");
        for (int c = 0; c < 12; c++) begin
            d = 8'($urandom);
            step(1'b0, 8'h06, d, 8'h02, "no_preempt");
        end
        step(1'b0, 8'h04, 8'h04, 8'h04, "np_release");
        step(1'b0, 8'h00, 8'h00, 8'h00, "np_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
